// File: rtl/axi_slave_write_ctrl.sv
// AXI slave write engine: accepts one AW burst at a time and its W beats.
// It generates per-beat byte addresses for FIXED/INCR/WRAP bursts, drives
// strobed byte-lane writes to the slave memory one cycle after each accepted
// beat, and returns a B response. The response carries the most severe error
// seen in the burst.
module axi_slave_write_ctrl #(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 3,
  parameter int ADDR_BITS = 12
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [WIDTH/8-1:0]     awid,
  input  logic [WIDTH-1:0]       awaddr,
  input  logic [WIDTH/8-1:0]     awlen,
  input  logic [SIZE-1:0]        awsize,
  input  logic [SIZE-2:0]        awburst,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [WIDTH/8-1:0]     wid,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [WIDTH/8-1:0]     wstrb,
  input  logic                   wlast,
  output logic                   bvalid,
  input  logic                   bready,
  output logic [WIDTH/8-1:0]     bid,
  output logic [SIZE-2:0]        bresp,
  output logic                   mem_we,
  output logic [ADDR_BITS-1:0]   mem_addr,
  output logic [WIDTH/8-1:0]     mem_be,
  output logic [WIDTH-1:0]       mem_wdata
);

  localparam int NB        = WIDTH / 8;
  localparam int LANE_BITS = $clog2(NB);

  localparam logic [SIZE-2:0] BURST_FIXED = (SIZE-1)'(0);
  localparam logic [SIZE-2:0] BURST_WRAP  = (SIZE-1)'(2);
  localparam logic [SIZE-2:0] BURST_RSVD  = (SIZE-1)'(3);

  localparam logic [SIZE-2:0] RESP_OKAY   = (SIZE-1)'(0);
  localparam logic [SIZE-2:0] RESP_SLVERR = (SIZE-1)'(2);
  localparam logic [SIZE-2:0] RESP_DECERR = (SIZE-1)'(3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_q;
  logic                 awready_q, wready_q, bvalid_q, mem_we_q;
  logic [NB-1:0]        bid_q, mem_be_q;
  logic [SIZE-2:0]      bresp_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic [WIDTH-1:0]     mem_wdata_q;

  // Captured burst context
  logic [NB-1:0]        awid_q, awlen_q, beat_q;
  logic [SIZE-1:0]      awsize_q;
  logic [SIZE-2:0]      awburst_q;
  logic [WIDTH-1:0]     addr_q;
  logic                 burst_bad_q;
  logic [SIZE-2:0]      err_q;

  // Combinational next-state and per-beat qualifiers
  logic [WIDTH-1:0]     addr_d;
  logic [SIZE-2:0]      err_d;
  logic [WIDTH-1:0]     size_bytes, aligned, wrap_mask, aw_size_bytes;
  logic [NB-1:0]        lane_mask;
  logic                 aw_bad, dec_err, id_err, last_beat, wlast_err, final_beat, suppress;
  logic [SIZE-2:0]      beat_err;
  int                   lane_lo, lane_hi;

  // Beat address sequencing, lane mask and error classification
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    size_bytes = WIDTH'(1) << awsize_q;
    aligned    = addr_q & ~(size_bytes - WIDTH'(1));
    wrap_mask  = ((WIDTH'(awlen_q) + WIDTH'(1)) << awsize_q) - WIDTH'(1);
    addr_d     = aligned + size_bytes;
    case (awburst_q)
      BURST_FIXED: addr_d = addr_q;
      BURST_WRAP:  addr_d = (addr_q & ~wrap_mask) | ((aligned + size_bytes) & wrap_mask);
      default:     addr_d = aligned + size_bytes;
    endcase

    lane_lo   = int'(addr_q[LANE_BITS-1:0]);
    lane_hi   = int'(aligned[LANE_BITS-1:0]) + int'(size_bytes) - 1;
    lane_mask = '0;
    for (int i = 0; i < NB; i++) begin
      lane_mask[i] = (i >= lane_lo) && (i <= lane_hi);
    end

    // Burst-wide faults detected on the AW handshake suppress every beat
    aw_size_bytes = WIDTH'(1) << awsize;
    aw_bad = (awsize > SIZE'(LANE_BITS)) || (awburst == BURST_RSVD) ||
             ((awburst == BURST_WRAP) &&
              ((awlen == '0) || ((awlen & (awlen + NB'(1))) != '0) ||
               ((awaddr & (aw_size_bytes - WIDTH'(1))) != '0)));

    dec_err    = addr_q[WIDTH-1:ADDR_BITS] != '0;
    id_err     = wid != awid_q;
    last_beat  = beat_q == awlen_q;
    wlast_err  = wlast != last_beat;
    final_beat = last_beat || wlast;
    suppress   = dec_err || burst_bad_q || id_err;

    beat_err = RESP_OKAY;
    if (dec_err)                                  beat_err = RESP_DECERR;
    else if (burst_bad_q || id_err || wlast_err)  beat_err = RESP_SLVERR;
    err_d = (beat_err > err_q) ? beat_err : err_q;
  end

  // Write FSM: all handshake and memory outputs are registered here
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      awid_q      <= '0;
      awlen_q     <= '0;
      awsize_q    <= '0;
      awburst_q   <= '0;
      addr_q      <= '0;
      beat_q      <= '0;
      burst_bad_q <= 1'b0;
      err_q       <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          awready_q <= 1'b1;
          if (awvalid && awready_q) begin
            awid_q      <= awid;
            awlen_q     <= awlen;
            awsize_q    <= awsize;
            awburst_q   <= awburst;
            addr_q      <= awaddr;
            beat_q      <= '0;
            burst_bad_q <= aw_bad;
            err_q       <= aw_bad ? RESP_SLVERR : RESP_OKAY;
            awready_q   <= 1'b0;
            wready_q    <= 1'b1;
            state_q     <= DATA;
          end
        end
        DATA: begin
          if (wvalid && wready_q) begin
            if (!suppress) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {addr_q[ADDR_BITS-1:LANE_BITS], {LANE_BITS{1'b0}}};
              mem_be_q    <= wstrb & lane_mask;
              mem_wdata_q <= wdata;
            end
            if (final_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= awid_q;
              bresp_q  <= err_d;
              state_q  <= RESP;
            end else begin
              err_q  <= err_d;
              addr_q <= addr_d;
              beat_q <= beat_q + NB'(1);
            end
          end
        end
        RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            awready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bid       = bid_q;
  assign bresp     = bresp_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule
